axis_uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous `uart_rx_i` line into bytes and presents them on an AXI-Stream master port. It sits directly upstream of the UART RX FIFO and register block, which consumes `m_axis_*` and reflects errors into the status register. Bit timing comes from the clock-divider control register, and parity mode from the control register's `parity_odd` and `parity_even` bits. The block uses mid-bit sampling with false-start rejection, parity and stop-bit checking, and overrun detection.

---
 rtl/axis_uart_rx.sv | 179 +++++++++++++++++
 tb/tb_axis_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// UART receiver: mid-bit sampling deserialiser with false-start rejection,
// parity/stop checking and an AXI-Stream master output with overrun detection.
module axis_uart_rx #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DIVIDER_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     uart_rx_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic [1:0]               m_axis_tuser_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     overrun_o
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                   state_q, state_d;
  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     prev_q, prev_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic [DIVIDER_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     parity_err_q, parity_err_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [1:0]               tuser_q, tuser_d;
  logic                     tvalid_q, tvalid_d;
  logic                     overrun_q, overrun_d;

  logic [DIVIDER_WIDTH-1:0] baud_target;
  logic                     baud_hit;
  logic                     byte_done;
  logic                     frame_err;
  logic                     par_expect;

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d      = state_q;
    sync1_d      = uart_rx_i;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    div_d        = div_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_err_d = parity_err_q;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    tvalid_d     = tvalid_q;
    overrun_d    = 1'b0;
    byte_done    = 1'b0;
    frame_err    = 1'b0;
    par_expect   = par_odd_q ? ~^shift_q : ^shift_q;

    // Start bit is sampled after half a bit, every later bit after a full bit
    baud_target = (state_q == S_START) ? ((div_q >> 1) - DIVIDER_WIDTH'(1))
                                       : (div_q - DIVIDER_WIDTH'(1));
    baud_hit    = (baud_cnt_q == baud_target);

    if (state_q != S_IDLE) begin
      baud_cnt_d = baud_hit ? '0 : baud_cnt_q + DIVIDER_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          div_d        = clk_divider_i;
          par_en_d     = parity_odd_i | parity_even_i;
          par_odd_d    = parity_odd_i;
          bit_cnt_d    = '0;
          baud_cnt_d   = '0;
          parity_err_d = 1'b0;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (baud_hit) begin
          state_d = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_hit) begin
          shift_d   = DATA_WIDTH'({sync2_q, shift_q} >> 1);
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_hit) begin
          parity_err_d = (sync2_q != par_expect);
          state_d      = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_hit) begin
          byte_done = 1'b1;
          frame_err = !sync2_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed byte is dropped only if the held beat is not leaving this cycle
    if (byte_done) begin
      if (!tvalid_q || m_axis_tready_i) begin
        tdata_d  = shift_q;
        tuser_d  = {frame_err, parity_err_q};
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (tvalid_q && m_axis_tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      div_q        <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      tvalid_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      div_q        <= div_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tvalid_q     <= tvalid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tuser_o  = tuser_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx: directed UART frames, expected beats queued at
// stimulus time and checked by an independent AXI-Stream monitor.
module tb_axis_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div = 32'd16;
  logic        par_odd = 1'b0;
  logic        par_even = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  tdata;
  logic [1:0]  tuser;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int vhi_cnt = 0;
  int ovr_cnt = 0;
  int ovr_base = 0;
  logic prev_valid = 1'b0;
  beat_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_uart_rx #(.DATA_WIDTH(8), .DIVIDER_WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clk_divider_i   (div),
    .parity_odd_i    (par_odd),
    .parity_even_i   (par_even),
    .uart_rx_i       (rx),
    .m_axis_tdata_o  (tdata),
    .m_axis_tuser_o  (tuser),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .overrun_o       (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned just after a rising edge; frame occupies bits*div cycles
  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par_bit,
                            input logic stop_bit, input int d);
    start_cyc = cyc;
    rx = 1'b0;
    wait_cyc(d);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(d);
    end
    if (has_par) begin
      rx = par_bit;
      wait_cyc(d);
    end
    rx = stop_bit;
    wait_cyc(d);
    rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] u);
    beat_t e;
    e.data = d;
    e.user = u;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every accepted beat, tracks tvalid and overrun
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tdata=0x%0h tuser=%0b expected none", tdata, tuser);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_tdata", 32'(tdata), 32'(e.data));
          chk("beat_tuser", 32'(tuser), 32'(e.user));
        end
      end
      if (tvalid && !prev_valid) rise_cyc = cyc;
      if (tvalid) vhi_cnt++;
      if (overrun) ovr_cnt++;
    end
    prev_valid = tvalid;
  end

  initial begin
    wait_cyc(3);
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tdata", 32'(tdata), 32'd0);
    chk("reset_tuser", 32'(tuser), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_cyc(3);

    // Clean byte and exact tvalid timing (pin edge + 2 sync cycles + 153)
    vhi_cnt = 0;
    push(8'hA5, 2'b00);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(10);
    chk("a5_rise_cycle", 32'(rise_cyc - start_cyc), 32'd155);
    chk("a5_valid_cycles", 32'(vhi_cnt), 32'd1);

    // Parity modes on 0x3C (even popcount), parity bit sent as 1
    par_odd = 1'b1;
    push(8'h3C, 2'b00);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    wait_cyc(10);
    par_odd = 1'b0;
    par_even = 1'b1;
    push(8'h3C, 2'b01);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    wait_cyc(10);
    par_odd = 1'b1;
    push(8'h3C, 2'b00);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    wait_cyc(10);
    par_odd = 1'b0;
    par_even = 1'b0;

    // Short glitch must be rejected as a false start
    vhi_cnt = 0;
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(40);
    chk("glitch_no_valid", 32'(vhi_cnt), 32'd0);

    // Framing error
    push(8'h55, 2'b10);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 16);
    wait_cyc(20);

    // Backpressure and overrun: second byte dropped
    tready = 1'b0;
    ovr_base = ovr_cnt;
    push(8'h11, 2'b00);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(5);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(5);
    chk("overrun_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("held_tdata", 32'(tdata), 32'h11);
    chk("held_tvalid", 32'(tvalid), 32'd1);
    tready = 1'b1;
    wait_cyc(10);
    chk("drained_tvalid", 32'(tvalid), 32'd0);

    // Handshake on the completion cycle of the second byte: both delivered
    tready = 1'b0;
    ovr_base = ovr_cnt;
    push(8'h11, 2'b00);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(5);
    push(8'h22, 2'b00);
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
      begin
        wait_cyc(154);
        tready = 1'b1;
      end
    join
    wait_cyc(10);
    chk("same_cycle_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    // Back-to-back frames at D = 4
    div = 32'd4;
    wait_cyc(4);
    push(8'h00, 2'b00);
    push(8'hFF, 2'b00);
    push(8'h81, 2'b00);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 4);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 4);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 4);
    wait_cyc(10);
    div = 32'd16;
    wait_cyc(4);

    // Reset during DATA clears a pending beat and aborts the frame
    tready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(5);
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16);
      begin
        wait_cyc(60);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
      end
    join
    wait_cyc(3);
    chk("reset_mid_frame_tvalid", 32'(tvalid), 32'd0);
    tready = 1'b1;
    wait_cyc(3);
    push(8'h7E, 2'b00);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 16);
    wait_cyc(10);

    // Divider change mid-frame does not affect the current frame
    push(8'hC3, 2'b00);
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16);
      begin
        wait_cyc(30);
        div = 32'd8;
      end
    join
    div = 32'd16;
    wait_cyc(20);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
